// File: rtl/key_inject_pkg.sv
// Shared types and constants for the keyboard-matrix key injector.
// Matrix bits are active-low and indexed row*KM_COLS+col.
package key_inject_pkg;

  localparam int KM_ROWS   = 12;
  localparam int KM_COLS   = 7;
  localparam int KM_BITS   = 84;
  localparam int SHIFT_ROW = 0;
  localparam int SHIFT_COL = 6;
  localparam int CTRL_ROW  = 1;
  localparam int CTRL_COL  = 6;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_HOLD,
    ST_REL_GAP
  } inj_state_e;

  typedef struct packed {
    logic       shift;
    logic       ctrl;
    logic [3:0] row;
    logic [2:0] col;
  } key_req_t;

  // Active-low mask for one request; the key bit itself is only pulled low when with_key is set.
  function automatic logic [KM_BITS-1:0] key_mask(input key_req_t k, input logic with_key);
    logic [KM_BITS-1:0] m;
    int idx;
    m = '1;
    if (k.shift) m[SHIFT_ROW*KM_COLS+SHIFT_COL] = 1'b0;
    if (k.ctrl)  m[CTRL_ROW*KM_COLS+CTRL_COL]   = 1'b0;
    idx = int'(k.row) * KM_COLS + int'(k.col);
    if (with_key && idx < KM_BITS) m[idx] = 1'b0;
    return m;
  endfunction

endpackage

// File: rtl/key_req_fifo.sv
// Request queue for the key injector: first-word-fall-through FIFO with
// extra-MSB pointers so full and empty are distinguishable.
module key_req_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop && !empty) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // NOTE: storage has no reset; entries are only observable once written, and an unreset array maps to RAM.
  always_ff @(posedge clk) begin
    if (push && !full && !flush) mem[wr_ptr[AW-1:0]] <= din;
  end

  assign dout  = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/key_inject_seq.sv
// Types queued key requests into the 12x7 keyboard matrix through timed
// modifier-setup / hold / release-gap phases; output is an active-low override.
module key_inject_seq
  import key_inject_pkg::*;
#(
  parameter int SETUP_CYCLES = 100000,
  parameter int HOLD_CYCLES  = 400000,
  parameter int GAP_CYCLES   = 400000,
  parameter int CNT_W        = 20,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [3:0]         req_row,
  input  logic [2:0]         req_col,
  input  logic               req_shift,
  input  logic               req_ctrl,
  input  logic               abort,
  output logic [KM_BITS-1:0] inj_km,
  output logic               busy,
  output logic               err_badcode
);

  inj_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  key_req_t           cur_q, cur_d;
  logic [KM_BITS-1:0] km_d;

  key_req_t fifo_din, fifo_dout;
  logic     fifo_full, fifo_empty, fifo_pop;
  logic     accept, code_ok;

  assign req_ready = !fifo_full && !abort;
  assign accept    = req_valid && req_ready;
  assign code_ok   = (req_row < 4'(KM_ROWS)) && (req_col < 3'(KM_COLS));
  assign fifo_din  = {req_shift, req_ctrl, req_row, req_col};
  assign busy      = !fifo_empty || (state_q != ST_IDLE);

  key_req_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH($bits(key_req_t))
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (accept && code_ok),
    .pop  (fifo_pop),
    .flush(abort),
    .din  (fifo_din),
    .dout (fifo_dout),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cur_d    = cur_q;
    fifo_pop = 1'b0;
    if (abort) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            cur_d    = fifo_dout;
            cnt_d    = CNT_W'(SETUP_CYCLES - 1);
            state_d  = ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (cnt_q == '0) begin
            cnt_d   = CNT_W'(HOLD_CYCLES - 1);
            state_d = ST_HOLD;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        ST_HOLD: begin
          if (cnt_q == '0) begin
            cnt_d   = CNT_W'(GAP_CYCLES - 1);
            state_d = ST_REL_GAP;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        ST_REL_GAP: begin
          if (cnt_q == '0) state_d = ST_IDLE;
          else             cnt_d   = cnt_q - 1'b1;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Matrix is registered from the next state so it changes on the same edge as the phase.
  always_comb begin
    km_d = '1;
    case (state_d)
      ST_SETUP: km_d = key_mask(cur_d, 1'b0);
      ST_HOLD:  km_d = key_mask(cur_d, 1'b1);
      default:  km_d = '1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      cur_q       <= '0;
      inj_km      <= '1;
      err_badcode <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cur_q       <= cur_d;
      inj_km      <= km_d;
      err_badcode <= accept && !code_ok;
    end
  end

endmodule

// File: tb/tb_key_inject_seq.sv
// Self-checking bench for key_inject_seq: directed scenarios plus random traffic
// checked every cycle against a per-key timing schedule model.
module tb_key_inject_seq;

  localparam int S   = 2;
  localparam int H   = 3;
  localparam int G   = 2;
  localparam int D   = 8;
  localparam int PER = S + H + G;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_row;
  logic [2:0]  req_col;
  logic        req_shift;
  logic        req_ctrl;
  logic        abort;
  logic [83:0] inj_km;
  logic        busy;
  logic        err_badcode;

  always #5 clk = ~clk;

  key_inject_seq #(
    .SETUP_CYCLES(S),
    .HOLD_CYCLES (H),
    .GAP_CYCLES  (G),
    .CNT_W       (20),
    .FIFO_DEPTH  (D)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_row    (req_row),
    .req_col    (req_col),
    .req_shift  (req_shift),
    .req_ctrl   (req_ctrl),
    .abort      (abort),
    .inj_km     (inj_km),
    .busy       (busy),
    .err_badcode(err_badcode)
  );

  // Model: each stored key gets a pop edge p; it occupies edges p .. p+PER-1.
  typedef struct {
    int p;
    int row;
    int col;
    bit sh;
    bit ct;
  } key_t;

  key_t keys[$];
  int   cyc       = 0;
  int   next_free = 0;
  bit   exp_err   = 1'b0;
  int   n_checks  = 0;
  int   n_pass    = 0;

  task automatic check(input string tag, input logic [83:0] got, input logic [83:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %h expected %h", tag, cyc, got, exp);
  endtask

  function automatic int fifo_cnt();
    int c = 0;
    foreach (keys[i]) if (keys[i].p > cyc) c++;
    return c;
  endfunction

  function automatic logic [83:0] exp_km();
    logic [83:0] m = '1;
    foreach (keys[i]) begin
      if (cyc >= keys[i].p && cyc < keys[i].p + S + H) begin
        if (keys[i].sh) m[6]  = 1'b0;
        if (keys[i].ct) m[13] = 1'b0;
      end
      if (cyc >= keys[i].p + S && cyc < keys[i].p + S + H)
        m[keys[i].row * 7 + keys[i].col] = 1'b0;
    end
    return m;
  endfunction

  function automatic bit exp_busy();
    foreach (keys[i]) if (cyc < keys[i].p + PER) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_edge(input bit acc, input int r, input int c, input bit sh, input bit ct,
                            input bit ab);
    key_t k;
    exp_err = 1'b0;
    if (ab) begin
      keys.delete();
      next_free = 0;
      return;
    end
    while (keys.size() > 0 && cyc >= keys[0].p + PER) void'(keys.pop_front());
    if (acc) begin
      if (r <= 11 && c <= 6) begin
        k.p   = (cyc + 1 > next_free) ? cyc + 1 : next_free;
        k.row = r;
        k.col = c;
        k.sh  = sh;
        k.ct  = ct;
        keys.push_back(k);
        next_free = k.p + PER + 1;
      end else begin
        exp_err = 1'b1;
      end
    end
  endtask

  // Entered and left at a falling edge; outputs reflect the state after edge 'cyc'.
  task automatic step(input bit v, input int r, input int c, input bit sh, input bit ct,
                      input bit ab, output bit acc);
    bit exp_ready;
    req_valid = v;
    req_row   = 4'(r);
    req_col   = 3'(c);
    req_shift = sh;
    req_ctrl  = ct;
    abort     = ab;
    #1;
    exp_ready = (fifo_cnt() < D) && !ab;
    check("inj_km", inj_km, exp_km());
    check("busy", busy, exp_busy());
    check("err_badcode", err_badcode, exp_err);
    check("req_ready", req_ready, exp_ready);
    acc = v && exp_ready;
    @(posedge clk);
    cyc++;
    model_edge(acc, r, c, sh, ct, ab);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    bit a;
    repeat (n) step(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, a);
  endtask

  initial begin
    bit acc;
    int i;
    int budget;
    reset     = 1'b1;
    req_valid = 1'b0;
    req_row   = '0;
    req_col   = '0;
    req_shift = 1'b0;
    req_ctrl  = 1'b0;
    abort     = 1'b0;
    #1;
    check("reset_km", inj_km, '1);
    check("reset_busy", busy, 1'b0);
    check("reset_err", err_badcode, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    // Plain key Q, then shifted key, then shift key combined with its own modifier.
    step(1'b1, 2, 5, 1'b0, 1'b0, 1'b0, acc);
    idle(12);
    step(1'b1, 3, 5, 1'b1, 1'b0, 1'b0, acc);
    idle(12);
    step(1'b1, 0, 6, 1'b1, 1'b1, 1'b0, acc);
    idle(12);

    // Back-to-back pushes until ten have been accepted.
    i = 0;
    budget = 0;
    while (i < 10 && budget < 200) begin
      step(1'b1, i % 12, i % 7, i[0], i[1], 1'b0, acc);
      if (acc) i++;
      budget++;
    end
    check("bp_accepts", 32'(i), 32'd10);
    idle(90);

    // Out-of-range codes are consumed but never stored.
    step(1'b1, 12, 0, 1'b0, 1'b0, 1'b0, acc);
    step(1'b1, 0, 7, 1'b1, 1'b0, 1'b0, acc);
    idle(2);
    step(1'b1, 15, 7, 1'b0, 1'b1, 1'b0, acc);
    step(1'b1, 11, 6, 1'b0, 1'b0, 1'b0, acc);
    idle(12);

    // Abort mid-hold with three requests queued, while a new request is offered.
    for (int k = 0; k < 4; k++) step(1'b1, 4 + k, k, 1'b1, 1'b0, 1'b0, acc);
    idle(1);
    step(1'b1, 5, 5, 1'b0, 1'b0, 1'b1, acc);
    idle(4);

    // Asynchronous reset between clock edges during hold.
    step(1'b1, 7, 3, 1'b0, 1'b1, 1'b0, acc);
    idle(4);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_km", inj_km, '1);
    check("async_reset_busy", busy, 1'b0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    keys.delete();
    next_free = 0;
    exp_err = 1'b0;
    cyc++;
    idle(2);

    // Random traffic including bad codes and occasional aborts.
    for (int n = 0; n < 400; n++) begin
      step($urandom_range(0, 2) == 0, int'($urandom_range(0, 12)), int'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 79) == 0, acc);
    end
    abort = 1'b0;
    idle(100);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
